uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that is the responder on the CPU data bus for the console window at 0x20000. CPU stores to the TXDATA register go into an 8-bit TX FIFO, which is serialised 8N1 on a `tx` pin. A store of the magic word 123456789 raises a `halt` pulse for the simulation harness. Reads return registered data one cycle after the address, the same timing as data RAM. The CPU's read mux ORs this block's `mem_rdata` with the RAM's.

---
 rtl/uart_mmio_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_tx_mmio.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout, transmitter state encoding and the harness halt word.
package uart_mmio_pkg;

  // Register indices (mem_addr[3:2]) inside the 16-byte window
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_TXDATA  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  // STATUS bit positions
  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 5;

  // Full-word store of this value to TXDATA stops the simulation harness
  localparam logic [31:0] HALT_MAGIC = 32'd123456789;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output.
// push is ignored when full unless a pop happens in the same cycle; pop is
// ignored when empty. dout always shows the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers and occupancy
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates reads
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Console UART transmitter on the CPU data bus. Stores to TXDATA queue bytes
// that are sent 8N1 on tx; STATUS and DIVISOR are readable with one-cycle
// registered read latency. A full-word magic store to TXDATA pulses halt.
module uart_tx_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0002_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_write,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        halt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic       sel;
  logic [1:0] idx;
  logic       halt_cond;
  logic       push_req;
  logic       status_wr;

  // FIFO interface
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_pop;

  // Register state
  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;
  logic        halt_q, halt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] status;
  logic [ST_COUNT_W-1:0] count_ext;

  // Transmitter state
  tx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        bit_end;
  logic [15:0] div_load;

  // Byte-offset bits never matter for word registers
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  // Address decode and write qualification
  always_comb begin
    sel       = (mem_addr[31:4] == BASE_ADDR[31:4]);
    idx       = mem_addr[3:2];
    halt_cond = sel && (idx == REG_TXDATA) && (mem_write == 4'hF) &&
                (mem_wdata == HALT_MAGIC);
    push_req  = sel && (idx == REG_TXDATA) && mem_write[0] && !halt_cond;
    status_wr = sel && (idx == REG_STATUS) && mem_write[0];
  end

  // Bit timing helpers and FIFO pop: pop when idle or at the end of a stop bit
  always_comb begin
    bit_end  = (cnt_q == 16'd0);
    div_load = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);
    fifo_pop = !fifo_empty &&
               ((state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end));
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_req),
    .din   (mem_wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // STATUS word assembly
  always_comb begin
    count_ext           = '0;
    count_ext[CW-1:0]   = fifo_count;
    status              = '0;
    status[ST_BUSY]     = (state_q != TX_IDLE);
    status[ST_FULL]     = fifo_full;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_OVF]      = ovf_q;
    status[ST_COUNT_LSB +: ST_COUNT_W] = count_ext;
  end

  // Next values for overflow, divisor, halt pulse and read data
  always_comb begin
    ovf_d = ovf_q;
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (status_wr && mem_wdata[ST_OVF])     ovf_d = 1'b0;

    div_d = div_q;
    if (sel && (idx == REG_DIVISOR)) begin
      if (mem_write[0]) div_d[7:0]  = mem_wdata[7:0];
      if (mem_write[1]) div_d[15:8] = mem_wdata[15:8];
    end

    halt_d = halt_cond;

    // Reads use pre-write register values, so a same-cycle write is not seen
    rdata_d = '0;
    if (sel) begin
      case (idx)
        REG_STATUS:  rdata_d = status;
        REG_DIVISOR: rdata_d = {16'd0, div_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  // Bus-side registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q   <= 1'b0;
      div_q   <= DIV_RESET;
      halt_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      halt_q  <= halt_d;
      rdata_q <= rdata_d;
    end
  end

  // Transmit FSM; tx is registered from the current state so each bit
  // appears one cycle after the state that produces it, keeping bit lengths
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        TX_START: tx_q <= 1'b0;
        TX_DATA:  tx_q <= shift_q[0];
        default:  tx_q <= 1'b1;
      endcase

      case (state_q)
        TX_IDLE: begin
          if (fifo_pop) begin
            shift_q <= fifo_dout;
            cnt_q   <= div_load;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            bit_q   <= 3'd0;
            cnt_q   <= div_load;
            state_q <= TX_DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            cnt_q <= div_load;
            if (bit_q == 3'd7) begin
              state_q <= TX_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            if (fifo_pop) begin
              shift_q <= fifo_dout;
              cnt_q   <= div_load;
              state_q <= TX_START;
            end else begin
              state_q <= TX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign mem_rdata = rdata_q;
  assign tx        = tx_q;
  assign halt      = halt_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: bus driver tasks, a serial-line monitor that pops
// expected bytes from a queue and checks every sample of each frame, and a
// set of directed register/timing checks.
module tb_uart_tx_mmio;

  localparam logic [31:0] A_STATUS  = 32'h0002_0000;
  localparam logic [31:0] A_TXDATA  = 32'h0002_0004;
  localparam logic [31:0] A_DIVISOR = 32'h0002_0008;
  localparam logic [31:0] A_RSVD    = 32'h0002_000C;
  localparam logic [31:0] MAGIC     = 32'd123456789;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [3:0]  mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        tx;
  logic        halt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         mon_div  = 4;
  bit         mon_en   = 1'b0;
  bit         mon_busy = 1'b0;

  uart_tx_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx        (tx),
    .halt      (halt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    mem_addr  = a;
    mem_write = m;
    mem_wdata = d;
    tick();
    mem_addr  = 32'h0;
    mem_write = 4'h0;
    mem_wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    mem_addr  = a;
    mem_write = 4'h0;
    tick();
    d = mem_rdata;
    mem_addr = 32'h0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    bus_write(A_TXDATA, 4'b0001, {24'd0, b});
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < max_cycles) begin
      tick();
      n++;
    end
    check("drained", (exp_q.size() == 0 && !mon_busy), 1);
    repeat (3) tick();
  endtask

  // ---------------- serial monitor / scoreboard ----------------
  initial begin
    logic [9:0] frame;
    logic [9:0] rx;
    logic [7:0] e;
    int         bad;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        bad = 0;
        rx  = '0;
        check("frame_expected", (exp_q.size() != 0), 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        frame = {1'b1, e, 1'b0};
        for (int k = 0; k < 10; k++) begin
          for (int j = 0; j < mon_div; j++) begin
            if (!(k == 0 && j == 0)) @(negedge clk);
            if (tx !== frame[k]) bad++;
            if (j == mon_div / 2) rx[k] = tx;
          end
        end
        check("frame_byte", {24'd0, rx[8:1]}, {24'd0, e});
        check("frame_stop", {31'd0, rx[9]}, 1);
        check("frame_bad_samples", bad, 0);
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    int          lows;

    reset     = 1'b0;
    mem_addr  = 32'h0;
    mem_write = 4'h0;
    mem_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_halt", halt, 0);
    check("rst_rdata", mem_rdata, 0);
    reset = 1'b1;
    tick();

    // 1: reset register values and unselected reads
    bus_read(A_STATUS, d);          check("t1_status", d, 32'h0000_0004);
    bus_read(A_DIVISOR, d);         check("t1_divisor", d, 32'd868);
    bus_read(32'h0001_0000, d);     check("t1_unsel", d, 0);
    bus_read(A_DIVISOR, d);
    bus_read(32'h0001_0008, d);     check("t1_unsel_idx2", d, 0);
    bus_read(A_RSVD, d);            check("t1_reserved", d, 0);
    check("t1_tx_idle", tx, 1);

    // 2: single frame with DIVISOR=4, exact start latency and busy flag
    bus_write(A_DIVISOR, 4'b0011, 32'd4);
    bus_read(A_DIVISOR, d);         check("t2_divisor", d, 32'd4);
    mon_div = 4;
    mon_en  = 1'b1;
    exp_q.push_back(8'h41);
    bus_write(A_TXDATA, 4'b0001, 32'h41);
    check("t2_tx_e0", tx, 1);
    tick();
    check("t2_tx_e1", tx, 1);
    tick();
    check("t2_tx_e2", tx, 0);
    repeat (3) tick();
    bus_read(A_STATUS, d);          check("t2_status_busy", d, 32'h0000_0005);
    wait_drain(200);
    bus_read(A_STATUS, d);          check("t2_status_idle", d, 32'h0000_0004);

    // 3: back-to-back frames with no idle gap
    start_q.delete();
    push_byte(8'h55);
    push_byte(8'hAA);
    wait_drain(300);
    check("t3_frames", start_q.size(), 2);
    if (start_q.size() == 2) check("t3_contig", start_q[1] - start_q[0], 40);

    // 4: overflow when pushing past FIFO depth while busy
    push_byte(8'($urandom_range(0, 255)));
    tick();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 8) exp_q.push_back(b);
      bus_write(A_TXDATA, 4'b0001, {24'd0, b});
    end
    bus_read(A_STATUS, d);          check("t4_status_ovf", d, 32'h0000_080B);
    bus_write(A_STATUS, 4'b0001, 32'h8);
    bus_read(A_STATUS, d);          check("t4_status_clr", d, 32'h0000_0803);
    wait_drain(1000);
    bus_read(A_STATUS, d);          check("t4_status_idle", d, 32'h0000_0004);

    // 5: magic store halts without pushing; partial-mask magic pushes 0x15
    check("t5_halt_pre", halt, 0);
    bus_write(A_TXDATA, 4'hF, MAGIC);
    check("t5_halt", halt, 1);
    tick();
    check("t5_halt_clear", halt, 0);
    bus_read(A_STATUS, d);          check("t5_status", d, 32'h0000_0004);
    exp_q.push_back(8'h15);
    bus_write(A_TXDATA, 4'h1, MAGIC);
    check("t5_nohalt", halt, 0);
    wait_drain(200);

    // 6: asynchronous reset during DATA bit 3
    mon_en = 1'b0;
    repeat (2) tick();
    bus_write(A_TXDATA, 4'b0001, 32'h00);
    repeat (19) tick();
    check("t6_bit3_low", tx, 0);
    #3;
    reset = 1'b0;
    #1;
    check("t6_async_tx", tx, 1);
    check("t6_async_rdata", mem_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    bus_read(A_STATUS, d);          check("t6_status", d, 32'h0000_0004);
    bus_read(A_DIVISOR, d);         check("t6_divisor", d, 32'd868);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("t6_tx_quiet", lows, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
